d_cache_axi_bridge: RTL and testbench



---
 rtl/d_cache_axi_bridge.sv | 168 ++++++++++++++++
 tb/tb_d_cache_axi_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_axi_bridge.sv
// Write-through D-cache to AXI4 single-beat bridge; optional posted-write buffer under DCACHE_AXI_POSTED_WRITE_EN.
// Latency: read/write m_ready 3 cycles after strobe with a zero-wait slave (posted write: 2 cycles).
// Backpressure: every AXI valid holds until its ready; new requests wait in IDLE while a write is unresponded.
module d_cache_axi_bridge #(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] AXI_ID  = 4'd1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic [31:0]        m_din,
    input  logic               m_strobe,
    input  logic               m_rw,
    output logic [31:0]        m_dout,
    output logic               m_ready,
    output logic [3:0]         arid,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [3:0]         wid,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [3:0]         bid,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic               bus_err
);

    typedef enum logic [2:0] {IDLE, RA, RD, WR, WB, DONE} state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] araddr_q, awaddr_q;
    logic [31:0]        wdata_q, m_dout_q;
    logic               arvalid_q, rready_q, m_ready_q;
    logic               aw_pend, w_pend, b_pend, bus_err_q;

    logic               wr_busy, aw_w_fin, b_fin, rd_hs;
    logic               rd_accept, wr_accept;

    // IDs, rlast and the byte offset carry no information for single-word traffic
    logic unused_in;
    assign unused_in = ^{rid, bid, rlast, m_a[1:0]};

    assign wr_busy   = aw_pend | w_pend | b_pend;
    assign aw_w_fin  = (aw_pend | w_pend) & (~aw_pend | awready) & (~w_pend | wready);
    assign b_fin     = b_pend & bvalid;
    assign rd_hs     = rready_q & rvalid;
    assign rd_accept = (state == IDLE) & m_strobe & ~m_rw & ~wr_busy;
    assign wr_accept = (state == IDLE) & m_strobe & m_rw & ~wr_busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_accept)
                    state_nxt = RA;
                else if (wr_accept)
                    state_nxt = WR;
            end
            RA:   if (arready) state_nxt = RD;
            RD:   if (rvalid) state_nxt = DONE;
`ifdef DCACHE_AXI_POSTED_WRITE_EN
            // Buffer already holds the write; AW/W/B drain in the background
            WR:   state_nxt = DONE;
`else
            WR:   if (aw_w_fin) state_nxt = WB;
`endif
            WB:   if (b_fin) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            m_dout_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            m_ready_q <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            b_pend    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            arvalid_q <= (state_nxt == RA);
            rready_q  <= (state_nxt == RD);
            m_ready_q <= (state_nxt == DONE);

            if (rd_accept)
                araddr_q <= {m_a[A_WIDTH-1:2], 2'b00};

            if (wr_accept) begin
                awaddr_q <= {m_a[A_WIDTH-1:2], 2'b00};
                wdata_q  <= m_din;
                aw_pend  <= 1'b1;
                w_pend   <= 1'b1;
            end else begin
                if (aw_pend && awready)
                    aw_pend <= 1'b0;
                if (w_pend && wready)
                    w_pend <= 1'b0;
            end

            if (aw_w_fin)
                b_pend <= 1'b1;
            else if (b_fin)
                b_pend <= 1'b0;

            if (rd_hs)
                m_dout_q <= rdata;

            if ((rd_hs && rresp != 2'b00) || (b_fin && bresp != 2'b00))
                bus_err_q <= 1'b1;
        end
    end

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = AXI_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = aw_pend;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = 4'hF;
    assign wlast   = 1'b1;
    assign wvalid  = w_pend;

    assign bready  = b_pend;
    assign m_dout  = m_dout_q;
    assign m_ready = m_ready_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_d_cache_axi_bridge.sv
// Bench for d_cache_axi_bridge: directed requests, scoreboard of expected completions, AXI slave model with per-channel delays.
module tb_d_cache_axi_bridge;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] m_a, m_din, m_dout;
    logic        m_strobe, m_rw, m_ready;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready, bus_err;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [3:0]  rid = 4'd0, bid = 4'd0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;
    logic        rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

    always #5 clk = ~clk;

    d_cache_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
        .clk(clk), .clrn(clrn),
        .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe), .m_rw(m_rw),
        .m_dout(m_dout), .m_ready(m_ready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_err(bus_err)
    );

    typedef struct {
        int          cyc;
        logic        is_rd;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0, fails = 0, done_cnt = 0, cyc = 0;

    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] rdata_v = 32'h0;
    logic [1:0]  rresp_v = 2'b00, bresp_v = 2'b00;
    logic        rd_pend = 0, aw_got = 0, w_got = 0, wr_resp = 0;
    logic        ar_hold = 0, aw_hold = 0, w_hold = 0;
    logic [31:0] ar_prev = 0, aw_prev = 0, w_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake tracking plus protocol checks on values as they stand at the edge
    always @(posedge clk) begin
        if (!clrn) begin
            rd_pend = 0; aw_got = 0; w_got = 0; wr_resp = 0;
            ar_hold = 0; aw_hold = 0; w_hold = 0;
        end else begin
            if (ar_hold) begin
                tests++;
                if (!arvalid || araddr != ar_prev) begin
                    fails++;
                    $display("FAIL ar_stable: arvalid=%0b araddr=%h, required 1 and %h", arvalid, araddr, ar_prev);
                end
            end
            if (aw_hold) begin
                tests++;
                if (!awvalid || awaddr != aw_prev) begin
                    fails++;
                    $display("FAIL aw_stable: awvalid=%0b awaddr=%h, required 1 and %h", awvalid, awaddr, aw_prev);
                end
            end
            if (w_hold) begin
                tests++;
                if (!wvalid || wdata != w_prev) begin
                    fails++;
                    $display("FAIL w_stable: wvalid=%0b wdata=%h, required 1 and %h", wvalid, wdata, w_prev);
                end
            end
            if (arvalid) begin
                tests++;
                if (aw_got || w_got || wr_resp || awvalid || wvalid) begin
                    fails++;
                    $display("FAIL read_order: arvalid=1 while write unresponded, required no read issue");
                end
            end
            ar_hold = arvalid && !arready; ar_prev = araddr;
            aw_hold = awvalid && !awready; aw_prev = awaddr;
            w_hold  = wvalid && !wready;   w_prev  = wdata;
            if (arvalid && arready) rd_pend = 1;
            if (rvalid && rready)   rd_pend = 0;
            if (awvalid && awready) aw_got = 1;
            if (wvalid && wready)   w_got = 1;
            if (bvalid && bready)   wr_resp = 0;
            if (aw_got && w_got) begin
                wr_resp = 1; aw_got = 0; w_got = 0;
            end
        end
    end

    // Slave drive, each ready/valid appearing after its configured number of wait cycles
    always @(negedge clk) begin
        if (!clrn) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
            rdata = 0; rresp = 0; bresp = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            arready = arvalid && (ar_cnt >= ar_dly);
            ar_cnt  = arvalid ? ar_cnt + 1 : 0;
            awready = awvalid && (aw_cnt >= aw_dly);
            aw_cnt  = awvalid ? aw_cnt + 1 : 0;
            wready  = wvalid && (w_cnt >= w_dly);
            w_cnt   = wvalid ? w_cnt + 1 : 0;
            rvalid  = rd_pend && (r_cnt >= r_dly);
            r_cnt   = rd_pend ? r_cnt + 1 : 0;
            rdata   = rvalid ? rdata_v : 32'h0;
            rresp   = rvalid ? rresp_v : 2'b00;
            rlast   = rvalid;
            rid     = 4'd1;
            bvalid  = wr_resp && (b_cnt >= b_dly);
            b_cnt   = wr_resp ? b_cnt + 1 : 0;
            bresp   = bvalid ? bresp_v : 2'b00;
            bid     = 4'd1;
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        if (clrn && m_ready) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_m_ready: pulse at cycle %0d, required no completion", cyc);
            end else begin
                e = sbq.pop_front();
                if (cyc != e.cyc || (e.is_rd && m_dout != e.dout) || bus_err != e.err) begin
                    fails++;
                    $display("FAIL completion: cycle=%0d m_dout=%h bus_err=%0b, required cycle=%0d m_dout=%h bus_err=%0b",
                             cyc, m_dout, bus_err, e.cyc, e.dout, e.err);
                end
            end
            done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Raise strobe until the bridge leaves IDLE; acc is the acceptance cycle (cycle 0)
    task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic [31:0] exp_dout, input logic exp_err, output int acc);
        exp_t e;
        m_a = a; m_din = d; m_rw = rw; m_strobe = 1'b1; acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            @(negedge clk); #1;
            if (arvalid || awvalid || wvalid) acc = cyc - 1;
        end
        m_strobe = 1'b0;
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL accept_timeout: request at %h not accepted in 40 cycles", a);
        end else begin
            e.cyc = acc + lat; e.is_rd = !rw; e.dout = exp_dout; e.err = exp_err;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 60 && done_cnt < n; i++) begin
            @(negedge clk); #1;
        end
        tests++;
        if (done_cnt < n) begin
            fails++;
            $display("FAIL done_timeout: completions=%0d, required %0d", done_cnt, n);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int acc, w0, n, awc, wc;
        n = 0;
        clrn = 1'b0; m_strobe = 1'b0; m_rw = 1'b0; m_a = 32'h0; m_din = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, m_ready}, 64'h0);
        check("rst_addr", {araddr, awaddr}, 64'h0);
        check("rst_data", {wdata, m_dout}, 64'h0);
        check("rst_bus_err", bus_err, 64'h0);
        clrn = 1'b1;
        @(negedge clk); #1;

        rdata_v = 32'hDEAD_BEEF;
        req(1'b0, 32'h1FC0_0014, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, acc);
        check("ar_fields", {araddr, arlen, arsize, arburst, arid},
              {32'h1FC0_0014, 8'd0, 3'b010, 2'b01, 4'd1});
        n++; wait_done(n);

        rdata_v = 32'h0BAD_F00D;
        req(1'b0, 32'h0000_1237, 32'h0, 3, 32'h0BAD_F00D, 1'b0, acc);
        check("ar_align", araddr, 64'h0000_1234);
        n++; wait_done(n);

`ifdef DCACHE_AXI_POSTED_WRITE_EN
        b_dly = 4;
        req(1'b1, 32'h8000_0200, 32'hCAFE_F00D, 2, 32'h0, 1'b0, w0);
        check("aw_fields", {awaddr, awlen, awsize, awburst, awid},
              {32'h8000_0200, 8'd0, 3'b010, 2'b01, 4'd1});
        rdata_v = 32'h1357_9BDF;
        req(1'b0, 32'h8000_0200, 32'h0, 3, 32'h1357_9BDF, 1'b0, acc);
        check("posted_read_accept", acc, w0 + 7);
        n += 2; wait_done(n);
        b_dly = 0;
`else
        aw_dly = 2; b_dly = 1;
        req(1'b1, 32'h8000_0100, 32'h1234_5678, 6, 32'h0, 1'b0, acc);
        check("aw_fields", {awaddr, awlen, awsize, awburst, awid},
              {32'h8000_0100, 8'd0, 3'b010, 2'b01, 4'd1});
        check("w_fields", {wdata, wstrb, wlast, wid}, {32'h1234_5678, 4'hF, 1'b1, 4'd1});
        awc = int'(awvalid); wc = int'(wvalid);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            awc += int'(awvalid); wc += int'(wvalid);
        end
        check("awvalid_cycles", awc, 64'd3);
        check("wvalid_cycles", wc, 64'd1);
        n++; wait_done(n);
        check("m_dout_hold", m_dout, 64'h0BAD_F00D);
        aw_dly = 0; b_dly = 0;
        req(1'b1, 32'h8000_0104, 32'h9ABC_DEF0, 3, 32'h0, 1'b0, acc);
        n++; wait_done(n);
`endif

        ar_dly = 5; rdata_v = 32'hA5A5_5A5A;
        req(1'b0, 32'h2000_0008, 32'h0, 8, 32'hA5A5_5A5A, 1'b0, acc);
        n++; wait_done(n);
        ar_dly = 0;

        rresp_v = 2'b10; rdata_v = 32'h1111_2222;
        req(1'b0, 32'h0000_0030, 32'h0, 3, 32'h1111_2222, 1'b1, acc);
        n++; wait_done(n);
        rresp_v = 2'b00; rdata_v = 32'h3333_4444;
        req(1'b0, 32'h0000_0034, 32'h0, 3, 32'h3333_4444, 1'b1, acc);
        n++; wait_done(n);
        check("bus_err_sticky", bus_err, 64'h1);

        // Abandon a read while the slave is still holding off rvalid
        r_dly = 20;
        m_a = 32'h0000_0044; m_rw = 1'b0; m_strobe = 1'b1;
        @(negedge clk); #1;
        m_strobe = 1'b0;
        @(negedge clk); #1;
        check("rd_state_rready", rready, 64'h1);
        @(negedge clk); #1;
        clrn = 1'b0;
        #1;
        check("midrst_valids", {arvalid, rready, awvalid, wvalid, bready, m_ready}, 64'h0);
        check("midrst_addr", {araddr, awaddr}, 64'h0);
        check("midrst_data", {wdata, m_dout}, 64'h0);
        check("midrst_bus_err", bus_err, 64'h0);
        @(negedge clk); #1;
        clrn = 1'b1; r_dly = 0;
        @(negedge clk); #1;
        rdata_v = 32'h7654_3210;
        req(1'b0, 32'h0000_0048, 32'h0, 3, 32'h7654_3210, 1'b0, acc);
        n++; wait_done(n);

        repeat (3) @(negedge clk);
        #1;
        check("sb_empty", sbq.size(), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
